// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instruction_fetch_unit_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned INSTR_STEP = 4;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } ifu_state_e;

    // Fetched word travelling with the PC it was read from.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_word_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_hold.sv
// fetch_hold_buffer: output register plus one-entry hold register that parks
// a word returned while the output is stalled; flush empties both.
module fetch_hold_buffer
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            push,
    input  fetch_word_t     push_word,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            instr_valid
);

    fetch_word_t hold_word;
    logic        hold_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_word   <= '{instr: NOP_INSTR, pc: RESET_PC};
            hold_valid  <= 1'b0;
            instruction <= NOP_INSTR;
            instr_pc    <= RESET_PC;
            pc_plus4    <= RESET_PC + XLEN'(INSTR_STEP);
            instr_valid <= 1'b0;
        end else if (flush) begin
            hold_valid  <= 1'b0;
            instr_valid <= 1'b0;
            instruction <= NOP_INSTR;
        end else if (hold_valid) begin
            // Parked word replaces the current one once it is consumed.
            if (!stall) begin
                instruction <= hold_word.instr;
                instr_pc    <= hold_word.pc;
                pc_plus4    <= hold_word.pc + XLEN'(INSTR_STEP);
                instr_valid <= 1'b1;
                hold_valid  <= 1'b0;
            end
        end else if (push) begin
            if (!instr_valid || !stall) begin
                instruction <= push_word.instr;
                instr_pc    <= push_word.pc;
                pc_plus4    <= push_word.pc + XLEN'(INSTR_STEP);
                instr_valid <= 1'b1;
            end else begin
                hold_word  <= push_word;
                hold_valid <= 1'b1;
            end
        end else if (instr_valid && !stall) begin
            instr_valid <= 1'b0;
            instruction <= NOP_INSTR;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, req/ack instruction-memory FSM, branch redirect/drain.
// Optional IFETCH_PERF_COUNT_EN adds FetchCount/StallCount outputs.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            Stall,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] BranchTarget,
    output logic            IMemReq,
    output logic [XLEN-1:0] IMemAddr,
    input  logic            IMemAck,
    input  logic [XLEN-1:0] IMemData,
    output logic [XLEN-1:0] Instruction,
    output logic [XLEN-1:0] InstrPC,
    output logic [XLEN-1:0] PCPlus4,
`ifdef IFETCH_PERF_COUNT_EN
    output logic [XLEN-1:0] FetchCount,
    output logic [XLEN-1:0] StallCount,
`endif
    output logic            InstrValid
);

    ifu_state_e      state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_inc_c;
    logic [XLEN-1:0] target_c;
    logic            ack_c;
    logic            slot_free_c;
    logic            push_c;
    fetch_word_t     push_word_c;

    assign pc_inc_c    = pc + XLEN'(INSTR_STEP);
    assign target_c    = word_align(BranchTarget);
    assign ack_c       = IMemReq & IMemAck;
    assign slot_free_c = !InstrValid || !Stall;
    assign push_c      = (state == FETCH) && ack_c && !PCSrc;
    assign push_word_c = '{instr: IMemData, pc: IMemAddr};

    // Request outputs are registered so IMemAck never reaches IMemReq combinationally.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            IMemReq  <= 1'b0;
            IMemAddr <= RESET_PC;
        end else if (PCSrc) begin
            pc <= target_c;
            if (IMemReq && !ack_c) begin
                state <= DRAIN;
            end else begin
                state    <= FETCH;
                IMemReq  <= 1'b1;
                IMemAddr <= target_c;
            end
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    IMemReq  <= 1'b1;
                    IMemAddr <= pc;
                end
                FETCH: begin
                    if (ack_c) begin
                        pc <= pc_inc_c;
                        if (slot_free_c) begin
                            IMemAddr <= pc_inc_c;
                        end else begin
                            state   <= HOLD;
                            IMemReq <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (!Stall) begin
                        state    <= FETCH;
                        IMemReq  <= 1'b1;
                        IMemAddr <= pc;
                    end
                end
                DRAIN: begin
                    if (ack_c) begin
                        state    <= FETCH;
                        IMemAddr <= pc;
                    end
                end
            endcase
        end
    end

    fetch_hold_buffer #(
        .RESET_PC(RESET_PC)
    ) u_hold (
        .clk        (Clk),
        .rst_n      (Rst),
        .stall      (Stall),
        .flush      (PCSrc),
        .push       (push_c),
        .push_word  (push_word_c),
        .instruction(Instruction),
        .instr_pc   (InstrPC),
        .pc_plus4   (PCPlus4),
        .instr_valid(InstrValid)
    );

`ifdef IFETCH_PERF_COUNT_EN
    // Output loads come from a direct push into a free slot or a hold release.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            FetchCount <= '0;
            StallCount <= '0;
        end else begin
            if ((push_c && slot_free_c) || (state == HOLD && !Stall && !PCSrc))
                FetchCount <= FetchCount + XLEN'(1);
            if (InstrValid && Stall)
                StallCount <= StallCount + XLEN'(1);
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: queue-based reference model
// compared every cycle, plus directed literal checks.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Stall, PCSrc, IMemAck;
    logic [31:0] BranchTarget, IMemData;
    logic        IMemReq, InstrValid;
    logic [31:0] IMemAddr, Instruction, InstrPC, PCPlus4;
`ifdef IFETCH_PERF_COUNT_EN
    logic [31:0] fetch_count, stall_count;
`endif

    int checks = 0;
    int failures = 0;
    int lat = 0;
    bit stray = 1'b0;

    instruction_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .Clk         (clk),
        .Rst         (rst_n),
        .Stall       (Stall),
        .PCSrc       (PCSrc),
        .BranchTarget(BranchTarget),
        .IMemReq     (IMemReq),
        .IMemAddr    (IMemAddr),
        .IMemAck     (IMemAck),
        .IMemData    (IMemData),
        .Instruction (Instruction),
        .InstrPC     (InstrPC),
        .PCPlus4     (PCPlus4),
`ifdef IFETCH_PERF_COUNT_EN
        .FetchCount  (fetch_count),
        .StallCount  (stall_count),
`endif
        .InstrValid  (InstrValid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0000_0104) return 32'h8C22_0004;
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of fetched-but-unconsumed words (front = output).
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } word_t;

    word_t       q[$];
    logic [31:0] m_pc = RST_PC;
    logic [31:0] m_addr = RST_PC;
    logic [31:0] m_last_pc = RST_PC;
    bit          m_req = 1'b0;
    bit          m_drain = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        bit acked;
        if (!rst_n) begin
            q.delete();
            m_pc = RST_PC; m_addr = RST_PC; m_last_pc = RST_PC;
            m_req = 1'b0; m_drain = 1'b0;
        end else begin
            acked = m_req && IMemAck;
            if (PCSrc) begin
                q.delete();
                m_pc = {BranchTarget[31:2], 2'b00};
                if (m_req && !acked) m_drain = 1'b1;
                else begin
                    m_drain = 1'b0; m_req = 1'b1; m_addr = m_pc;
                end
            end else begin
                if (q.size() > 0 && !Stall) q.delete(0);
                if (acked && !m_drain) begin
                    q.push_back('{mem(m_addr), m_addr});
                    m_pc = m_addr + 32'd4;
                end
                if (acked) m_drain = 1'b0;
                if (!m_req || acked) begin
                    m_req  = (q.size() < 2);
                    m_addr = m_pc;
                end
            end
            if (q.size() > 0) m_last_pc = q[0].pc;
        end
    end

    // Compare process: outputs are stable at the falling edge.
    always @(negedge clk) begin
        check("imem_req", {31'd0, IMemReq}, {31'd0, m_req});
        if (m_req) check("imem_addr", IMemAddr, m_addr);
        check("instr_valid", {31'd0, InstrValid}, {31'd0, q.size() > 0});
        check("instruction", Instruction, (q.size() > 0) ? q[0].instr : 32'h0);
        check("instr_pc", InstrPC, m_last_pc);
        check("pc_plus4", PCPlus4, m_last_pc + 32'd4);
    end

    // Memory responder: ack after `lat` waiting cycles; stray acks when idle.
    initial begin
        int age = 0;
        IMemAck = 1'b0; IMemData = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                IMemAck = stray; age = 0;
            end else begin
                if (IMemAck) age = 0;
                if (IMemReq) begin
                    IMemAck = (age >= lat);
                    if (!IMemAck) age++;
                    IMemData = IMemAck ? mem(IMemAddr) : 32'hDEAD_DEAD;
                end else begin
                    IMemAck = stray; age = 0;
                    IMemData = 32'hBAD0_BAD0;
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_req(input logic [31:0] addr, input int max_cycles);
        int n = 0;
        while (!(IMemReq && IMemAddr == addr) && n < max_cycles) begin
            step(); n++;
        end
        check("wait_req", (IMemReq && IMemAddr == addr) ? addr : IMemAddr, addr);
    endtask

    initial begin
        logic [19:0] stall_pat;
        stall_pat = 20'b0110_0011_1000_1101_0010;
        rst_n = 1'b0; Stall = 1'b0; PCSrc = 1'b0; BranchTarget = 32'h0;
        step(); step();
        check("rst_req", {31'd0, IMemReq}, 32'd0);
        check("rst_addr", IMemAddr, 32'h0000_0100);
        check("rst_pc4", PCPlus4, 32'h0000_0104);
        check("rst_instr", Instruction, 32'h0);

        // Zero-wait streaming from RESET_PC.
        rst_n = 1'b1;
        step();
        check("first_addr", IMemAddr, 32'h0000_0100);
        step();
        check("addr_104", IMemAddr, 32'h0000_0104);
        check("ipc_100", InstrPC, 32'h0000_0100);
        step();
        check("addr_108", IMemAddr, 32'h0000_0108);
        check("instr_104", Instruction, 32'h8C22_0004);

        // Stall three edges; next word parks in HOLD, stray acks ignored.
        Stall = 1'b1; stray = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_hold", Instruction, 32'h8C22_0004);
            check("stall_noreq", {31'd0, IMemReq}, 32'd0);
        end
        Stall = 1'b0; stray = 1'b0; lat = 4;
        step();
        check("release_ipc", InstrPC, 32'h0000_0108);
        check("release_addr", IMemAddr, 32'h0000_010C);

        // Redirect while 0x10C is unacked: drain, then fetch at 0x200.
        PCSrc = 1'b1; BranchTarget = 32'h0000_0203;
        step();
        PCSrc = 1'b0;
        check("drain_addr", IMemAddr, 32'h0000_010C);
        check("drain_instr", Instruction, 32'h0);
        wait_req(32'h0000_0200, 12);
        check("post_drain_valid", {31'd0, InstrValid}, 32'd0);
        lat = 0;
        step(); step();
        check("ipc_200", InstrPC, 32'h0000_0200);

        // Redirect and stall together with a valid output; target wraps.
        Stall = 1'b1; PCSrc = 1'b1; BranchTarget = 32'hFFFF_FFFE;
        step();
        PCSrc = 1'b0; Stall = 1'b0;
        check("flush_valid", {31'd0, InstrValid}, 32'd0);
        check("flush_instr", Instruction, 32'h0);
        check("wrap_req", IMemAddr, 32'hFFFF_FFFC);
        step();
        check("wrap_ipc", InstrPC, 32'hFFFF_FFFC);
        check("wrap_pc4", PCPlus4, 32'h0000_0000);
        check("wrap_next", IMemAddr, 32'h0000_0000);

        // Mixed stall pattern with one-wait memory.
        lat = 1;
        for (int i = 0; i < 20; i++) begin
            Stall = stall_pat[i];
            step();
        end
        Stall = 1'b0;

        // Reset mid-transaction, stray ack during reset and IDLE.
        lat = 3;
        step();
        rst_n = 1'b0; stray = 1'b1;
        step();
        check("mid_rst_req", {31'd0, IMemReq}, 32'd0);
        check("mid_rst_valid", {31'd0, InstrValid}, 32'd0);
        rst_n = 1'b1;
        step();
        stray = 1'b0;
        check("restart_addr", IMemAddr, 32'h0000_0100);
        for (int i = 0; i < 12; i++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage that produces the 32-bit `Instruction` word consumed by `Controller` and `ALUControl`, closing the loop on the decode side. It owns the PC and issues one request at a time over a req/ack instruction-memory handshake. It presents each fetched word with its PC through a one-entry output register honouring a downstream `Stall`, and accepts branch redirects (`PCSrc`/`BranchTarget`) that flush in-flight work.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `Clk`  in  1: sole clock, rising edge.
- `Rst`  in  1: asynchronous, active-low reset.
- `Stall`  in  1: downstream cannot accept; held output must not change.
- `PCSrc`  in  1: redirect request; takes priority over everything.
- `BranchTarget`  in  32: redirect PC; bits [1:0] forced to 0.
- `IMemReq`  out  1: instruction-memory request.
- `IMemAddr`  out  32: word address of request (bits [1:0] always 0).
- `IMemAck`  in  1: memory returns `IMemData` this cycle; valid only while `IMemReq`=1.
- `IMemData`  in  32: fetched word.
- `Instruction`  out  32: current instruction to decode.
- `InstrPC`  out  32: PC of `Instruction`.
- `PCPlus4`  out  32: `InstrPC`+4, modulo 2^32.
- `InstrValid`  out  1: `Instruction` is a real fetched word.

## Operation
- States: IDLE, FETCH, HOLD, DRAIN.
- IDLE: reset state; `IMemReq`=0; unconditionally to FETCH next cycle.
- FETCH: `IMemReq`=1, `IMemAddr`=PC. On `IMemAck`:
  - output slot free (`InstrValid`=0 or `Stall`=0): load `Instruction`/`InstrPC`, set `InstrValid`, PC<=PC+4, stay in FETCH.
  - slot full and `Stall`=1: capture word in hold register, PC<=PC+4, go to HOLD.
- HOLD: `IMemReq`=0. When `Stall`=0, hold register moves to output, then FETCH.
- Consumption: an output word is consumed on any edge where `InstrValid`=1 and `Stall`=0; with no new word, `InstrValid`<=0 and `Instruction`<=NOP.
- Protocol: once raised, `IMemReq` stays high with stable `IMemAddr` until `IMemAck`; a request is never withdrawn.
- Redirect (`PCSrc`=1), any state:
  - PC<={BranchTarget[31:2],2'b00}.
  - Output flushed: `InstrValid`<=0, `Instruction`<=NOP (32'h0000_0000).
  - Hold register discarded.
  - FETCH with unacked request: go to DRAIN. With ack in the same cycle: word dropped, stay in FETCH.
  - HOLD: go to FETCH.
- DRAIN: `IMemReq`=1 with old address until `IMemAck`; returned data discarded, then FETCH at the redirected PC. A further `PCSrc` in DRAIN only updates PC.
- Redirect and `Stall` in the same cycle: redirect wins; flush happens regardless of `Stall`.
- PC arithmetic: 32-bit, wraps 32'hFFFF_FFFC -> 32'h0000_0000 without a flag.

## Timing
- Reset values: `IMemReq`=0, `IMemAddr`=RESET_PC, `Instruction`=0, `InstrPC`=RESET_PC, `PCPlus4`=RESET_PC+4, `InstrValid`=0, PC=RESET_PC, state IDLE.
- Reset mid-transaction aborts immediately; any later `IMemAck` for the old request arrives while `IMemReq`=0 and is ignored.
- First request: first cycle after `Rst` deasserts plus one (IDLE cycle).
- Latency: `Instruction` is valid the edge after `IMemAck`.
- Throughput: with zero-wait memory (ack in the request cycle), one instruction per cycle.
- `IMemReq`, `IMemAddr` are decoded from state/PC registers; there is no combinational path from `IMemAck` to `IMemReq`.
- `PCSrc` takes effect at the next edge; the first redirected request appears the cycle after that, or after the DRAIN ack.

## Configuration
- `IFETCH_PERF_COUNT_EN` defined:
  - adds outputs `FetchCount` (32, counts output loads) and `StallCount` (32, counts cycles with `InstrValid`=1 and `Stall`=1);
  - both counters clear on reset and wrap.
- Macro undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package/header holds:
  - state encodings: IDLE=2'd0, FETCH=2'd1, HOLD=2'd2, DRAIN=2'd3;
  - `NOP_INSTR`=32'h0000_0000;
  - `INSTR_STEP`=4.
- One sub-module: `fetch_hold_buffer`, the one-entry hold register plus output register with valid/stall/flush logic. The FSM and PC stay in the top module.

## Test plan
- Reset release, RESET_PC=0x100, zero-wait memory, `Stall`=0 -> requests to 0x100, 0x104, 0x108 on consecutive cycles; `InstrPC` follows one cycle behind with `InstrValid`=1.
- `Stall` high for 3 cycles with word 0x8C220004 at 0x104 -> `Instruction` held at 0x8C220004; the next word is parked in HOLD with `IMemReq`=0; no word is lost or duplicated after release.
- `IMemAck` delayed 4 cycles -> `IMemReq`/`IMemAddr` stable all 4 cycles; `InstrValid`=0 until the edge after ack.
- `PCSrc`=1, `BranchTarget`=0x203 while a request to 0x10C is unacked -> DRAIN until ack; data dropped, output NOP/invalid; next request address 0x200.
- `PCSrc` and `Stall` both asserted with a valid output -> `InstrValid`=0 and `Instruction`=0 next cycle.
- PC=0xFFFFFFFC fetched -> next request 0x00000000; `PCPlus4`=0x00000000.
